// File: rtl/skid_buffer_stage.sv
// Two-entry valid/ready skid buffer: registered valid, data, ready and occupancy.
// Accepted beats appear on o_data the cycle after acceptance; the skid entry absorbs the beat that lands while o_ready falls.
module skid_buffer_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   main_q, main_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [1:0]              count_q, count_d;
  logic                    in_fire;
  logic                    out_fire;

  assign in_fire  = i_valid & ready_q;
  assign out_fire = valid_q & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = i_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = i_data;
        end else if (in_fire) begin
          skid_d  = i_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs are decoded from the next state so every port is a flop.
  always_comb begin
    ready_d = (state_d != FULL);
    valid_d = (state_d != EMPTY);
    case (state_d)
      BUSY:    count_d = 2'd1;
      FULL:    count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = main_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_skid_buffer_stage.sv
// Directed vector table plus reset, random-scoreboard and reset-while-full sequences for skid_buffer_stage.
module tb_skid_buffer_stage;

  typedef struct packed {
    logic       iv;
    logic [7:0] id;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic       ordy;
    logic [1:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_ready;
  logic [1:0] o_count;

  int n_total = 0;
  int n_pass  = 0;

  skid_buffer_stage #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    i_valid = v.iv;
    i_data  = v.id;
    i_ready = v.ir;
    @(posedge clk);
    #1;
    check({nm, ".o_valid"}, 32'(o_valid), 32'(v.ov));
    check({nm, ".o_data"},  32'(o_data),  32'(v.od));
    check({nm, ".o_ready"}, 32'(o_ready), 32'(v.ordy));
    check({nm, ".o_count"}, 32'(o_count), 32'(v.cnt));
  endtask

  task automatic release_reset(input string nm);
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b0;
    reset   = 1'b0;
    #1;
    check({nm, ".ready_before_clk"}, 32'(o_ready), 32'd0);
    @(posedge clk);
    #1;
    check({nm, ".ready_after_clk"}, 32'(o_ready), 32'd1);
    check({nm, ".valid_after_clk"}, 32'(o_valid), 32'd0);
    check({nm, ".count_after_clk"}, 32'(o_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [7:0] b;
    logic [7:0] mq[$];
    logic [7:0] m_last;
    logic [7:0] exp_d;
    logic       m_in;
    logic       m_out;
    logic       pend;
    int         sent;
    int         cyc;

    // Streaming 0x01..0x10 with i_ready held high: one beat per cycle, 1-cycle latency.
    for (int k = 1; k <= 16; k++) begin
      b = 8'(k);
      tbl.push_back('{1'b1, b, 1'b1, 1'b1, b, 1'b1, 2'd1});
    end
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 1'b1, 2'd0});
    // Stall while BUSY keeps o_data stable.
    tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 8'h44, 1'b0, 1'b1, 8'h33, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 8'h44, 1'b1, 1'b0, 8'h33, 1'b1, 2'd0});
    // Skid fill with i_ready low, then drain.
    tbl.push_back('{1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2});
    tbl.push_back('{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2});
    tbl.push_back('{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 1'b1, 2'd1});
    tbl.push_back('{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'hA3, 1'b1, 2'd0});

    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_ready = 1'b0;
    #1;
    check("por.o_valid", 32'(o_valid), 32'd0);
    check("por.o_ready", 32'(o_ready), 32'd0);
    check("por.o_count", 32'(o_count), 32'd0);
    check("por.o_data",  32'(o_data),  32'd0);
    repeat (2) @(posedge clk);
    release_reset("por");

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Mid-cycle reset while holding a beat.
    apply('{1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 1'b1, 2'd1}, "pre_rst");
    #3;
    reset = 1'b1;
    #1;
    check("midrst.o_valid", 32'(o_valid), 32'd0);
    check("midrst.o_ready", 32'(o_ready), 32'd0);
    check("midrst.o_count", 32'(o_count), 32'd0);
    check("midrst.o_data",  32'(o_data),  32'd0);
    release_reset("midrst");
    // Nothing accepted in the cycle o_ready was still low after release.
    check("midrst.no_accept", 32'(o_valid), 32'd0);

    // Random traffic against a 2-entry reference model; upstream holds until accepted.
    m_last = 8'h00;
    pend   = 1'b0;
    sent   = 0;
    cyc    = 0;
    while ((sent < 1000 || mq.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      if (!pend) begin
        if (sent < 1000) begin
          i_valid = 1'($urandom_range(0, 1));
          i_data  = 8'(sent ^ (sent >> 8));
        end else begin
          i_valid = 1'b0;
        end
      end
      i_ready = 1'($urandom_range(0, 1));
      m_in  = i_valid && (mq.size() < 2);
      m_out = (mq.size() > 0) && i_ready;
      @(posedge clk);
      #1;
      if (m_out) void'(mq.pop_front());
      if (m_in) begin
        mq.push_back(i_data);
        sent++;
      end
      pend = i_valid && !m_in;
      if (mq.size() > 0) m_last = mq[0];
      exp_d = m_last;
      check("rnd.o_valid", 32'(o_valid), 32'(mq.size() > 0));
      check("rnd.o_ready", 32'(o_ready), 32'(mq.size() < 2));
      check("rnd.o_count", 32'(o_count), 32'(mq.size()));
      check("rnd.o_data",  32'(o_data),  32'(exp_d));
      cyc++;
    end
    check("rnd.beats_sent", 32'(sent), 32'd1000);
    check("rnd.model_drained", 32'(mq.size()), 32'd0);

    // Reset while FULL discards both beats.
    apply('{1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 2'd1}, "full55");
    apply('{1'b1, 8'h66, 1'b0, 1'b1, 8'h55, 1'b0, 2'd2}, "full66");
    #3;
    reset = 1'b1;
    #1;
    check("fullrst.o_valid", 32'(o_valid), 32'd0);
    check("fullrst.o_count", 32'(o_count), 32'd0);
    check("fullrst.o_ready", 32'(o_ready), 32'd0);
    release_reset("fullrst");
    apply('{1'b1, 8'h77, 1'b0, 1'b1, 8'h77, 1'b1, 2'd1}, "after77");
    apply('{1'b0, 8'h00, 1'b1, 1'b0, 8'h77, 1'b1, 2'd0}, "drain77");
    apply('{1'b0, 8'h00, 1'b1, 1'b0, 8'h77, 1'b1, 2'd0}, "idle77");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
